car_move_resolver: RTL and testbench

CAR_MOVE_RESOLVER -- requirements
Module: car_move_resolver

---
 rtl/car_move_resolver.sv | 168 ++++++++++++++++
 tb/tb_car_move_resolver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/car_move_resolver.sv
// car_move_resolver
//   Resolves one lane-change request per row-advance tick for a lane-based
//   car game. A request is latched while idle. On tick, the incoming row maps
//   are captured and evaluated one cycle later against the target lane. The
//   evaluation produces either a move, a stay, or a hit. A hit costs a life
//   and grants a few evaluations of immunity. Running out of lives ends the
//   game.
//
//   Ports
//     clk           clock
//     reset         synchronous, active-high
//     tick          one-cycle row-advance strobe
//     next_row      obstacle map of the row entering the car's tail slot
//     head_row      obstacle map of the row at the car's head
//     attempt_move  10 = left (+1), 01 = right (-1), 00/11 = none
//     position      current lane (0 = rightmost)
//     move_result   00 stay, 10 moved left, 01 moved right, 11 hit
//     result_valid  one-cycle pulse qualifying move_result
//     immune        immunity active
//     lives_left    remaining lives
//     game_over     sticky end-of-game flag
//     tick_overrun  one-cycle pulse when a tick is dropped
module car_move_resolver #(
  parameter int LANES        = 6,
  parameter int IMMUNE_TICKS = 3,
  parameter int LIVES        = 3,
  parameter int START_LANE   = 0,
  localparam int PW          = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [LANES-1:0] next_row,
  input  logic [LANES-1:0] head_row,
  input  logic [1:0]       attempt_move,
  output logic [PW-1:0]    position,
  output logic [1:0]       move_result,
  output logic             result_valid,
  output logic             immune,
  output logic [3:0]       lives_left,
  output logic             game_over,
  output logic             tick_overrun
);

  typedef enum logic [1:0] {IDLE, EVAL, CLEAR, OVER} state_t;

  localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);

  state_t           r_state;
  logic [1:0]       r_move;
  logic [LANES-1:0] r_next_row;
  logic [LANES-1:0] r_head_row;
  logic [PW-1:0]    r_position;
  logic [1:0]       r_move_result;
  logic             r_result_valid;
  logic             r_immune;
  logic [31:0]      r_count;
  logic [3:0]       r_lives;
  logic             r_game_over;
  logic             r_tick_overrun;

  logic [PW-1:0]    w_target;
  logic             w_applied;
  logic             w_hit;
  logic             w_req_valid;
  logic [31:0]      w_count_inc;

  // Only 10 and 01 are real requests.
  assign w_req_valid = attempt_move[1] ^ attempt_move[0];
  assign w_count_inc = r_count + 32'd1;

  // Target lane: walls clamp the move, leaving the car in place.
  always_comb begin
    w_target = r_position;
    if (r_move == 2'b10 && r_position != LAST_LANE) begin
      w_target = r_position + PW'(1);
    end else if (r_move == 2'b01 && r_position != '0) begin
      w_target = r_position - PW'(1);
    end
  end

  assign w_applied = (w_target != r_position);
  // The head row only matters when the car actually changes lane.
  assign w_hit     = !r_immune &&
                     (r_next_row[w_target] || (w_applied && r_head_row[w_target]));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_move         <= '0;
      r_next_row     <= '0;
      r_head_row     <= '0;
      r_position     <= PW'(START_LANE);
      r_move_result  <= '0;
      r_result_valid <= 1'b0;
      r_immune       <= 1'b0;
      r_count        <= '0;
      r_lives        <= 4'(LIVES);
      r_game_over    <= 1'b0;
      r_tick_overrun <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_tick_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_move == 2'b00 && w_req_valid) begin
            r_move <= attempt_move;
          end
          if (tick) begin
            r_next_row <= next_row;
            r_head_row <= head_row;
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          r_tick_overrun <= tick;
          r_result_valid <= 1'b1;
          if (w_hit) begin
            r_move_result <= 2'b11;
            r_immune      <= 1'b1;
            r_count       <= '0;
            if (r_lives != '0) begin
              r_lives <= r_lives - 4'd1;
            end
          end else begin
            r_move_result <= w_applied ? r_move : 2'b00;
            r_position    <= w_target;
            // The hitting evaluation itself never counts toward immunity.
            if (r_immune) begin
              if (w_count_inc == 32'(IMMUNE_TICKS)) begin
                r_immune <= 1'b0;
                r_count  <= '0;
              end else begin
                r_count <= w_count_inc;
              end
            end
          end
          r_state <= CLEAR;
        end
        CLEAR: begin
          r_tick_overrun <= tick;
          r_move         <= '0;
          if (r_lives == '0) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        OVER: begin
          r_game_over <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign position     = r_position;
  assign move_result  = r_move_result;
  assign result_valid = r_result_valid;
  assign immune       = r_immune;
  assign lives_left   = r_lives;
  assign game_over    = r_game_over;
  assign tick_overrun = r_tick_overrun;

endmodule

// File: tb/tb_car_move_resolver.sv
// Randomized scoreboard bench for car_move_resolver (default parameters).
// The reference model tracks the game in plain integers and cycle numbers:
// a tick is accepted when at least three cycles have passed since the last
// accepted one, evaluated on the next edge, and the request window is closed
// on the edge after that.
module tb_car_move_resolver;

  localparam int LANES = 6;
  localparam int IMM   = 3;
  localparam int LIVES = 3;
  localparam int START = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic [LANES-1:0] next_row;
  logic [LANES-1:0] head_row;
  logic [1:0]       attempt_move;
  logic [2:0]       position;
  logic [1:0]       move_result;
  logic             result_valid;
  logic             immune;
  logic [3:0]       lives_left;
  logic             game_over;
  logic             tick_overrun;

  car_move_resolver #(
    .LANES(LANES), .IMMUNE_TICKS(IMM), .LIVES(LIVES), .START_LANE(START)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .next_row(next_row),
    .head_row(head_row), .attempt_move(attempt_move), .position(position),
    .move_result(move_result), .result_valid(result_valid), .immune(immune),
    .lives_left(lives_left), .game_over(game_over), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc      = 0;
  int last_acc = -100;
  int m_pos    = START;
  int m_lives  = LIVES;
  int m_cnt    = 0;
  int m_pend   = 0;
  int m_res    = 0;
  bit m_imm    = 0;
  bit m_over   = 0;
  bit exp_ovr  = 0;
  logic [LANES-1:0] m_next = '0;
  logic [LANES-1:0] m_head = '0;
  int q[$];

  task automatic evaluate();
    int dir;
    int tgt;
    bit app;
    dir = (m_pend == 2) ? 1 : (m_pend == 1) ? -1 : 0;
    tgt = m_pos + dir;
    if (tgt < 0) tgt = 0;
    if (tgt > LANES - 1) tgt = LANES - 1;
    app = (tgt != m_pos);
    if (!m_imm && (m_next[tgt] || (app && m_head[tgt]))) begin
      m_res   = 3;
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_imm   = 1;
      m_cnt   = 0;
    end else begin
      m_res = app ? m_pend : 0;
      m_pos = tgt;
      if (m_imm) begin
        m_cnt++;
        if (m_cnt == IMM) begin
          m_imm = 0;
          m_cnt = 0;
        end
      end
    end
    q.push_back(m_res);
  endtask

  always @(posedge clk) begin
    int d;
    cyc++;
    exp_ovr = 0;
    if (reset) begin
      last_acc = -100;
      m_pos = START; m_lives = LIVES; m_cnt = 0; m_pend = 0; m_res = 0;
      m_imm = 0; m_over = 0;
    end else if (!m_over) begin
      d = cyc - last_acc;
      if (d == 1) begin
        evaluate();
      end else if (d == 2) begin
        m_pend = 0;
        if (m_lives == 0) m_over = 1;
      end
      if (tick && (d == 1 || d == 2)) exp_ovr = 1;
      if (d >= 3) begin
        if (m_pend == 0 && (attempt_move == 2'b10 || attempt_move == 2'b01))
          m_pend = int'(attempt_move);
        if (tick) begin
          last_acc = cyc;
          m_next   = next_row;
          m_head   = head_row;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int e;
    chk("tick_overrun", int'(tick_overrun), int'(exp_ovr));
    chk("game_over", int'(game_over), int'(m_over));
    chk("position", int'(position), m_pos);
    chk("lives_left", int'(lives_left), m_lives);
    chk("immune", int'(immune), int'(m_imm));
    chk("move_result_held", int'(move_result), m_res);
    if (result_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("move_result", int'(move_result), e);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("missing_result_valid", 0, 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int dens;
    reset = 1'b1; tick = 1'b0; next_row = '0; head_row = '0; attempt_move = 2'b00;
    repeat (2) @(negedge clk);
    for (int ep = 0; ep < 8; ep++) begin
      case (ep % 4)
        0: dens = 0;
        1: dens = 10;
        2: dens = 25;
        default: dens = 50;
      endcase
      reset = 1'b1;
      tick  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
        tick         = ($urandom_range(0, 2) == 0);
        attempt_move = 2'($urandom_range(0, 3));
        for (int l = 0; l < LANES; l++) begin
          next_row[l] = ($urandom_range(0, 99) < dens);
          head_row[l] = ($urandom_range(0, 99) < dens);
        end
        reset = (ep > 0) && ($urandom_range(0, 149) == 0);
        @(negedge clk);
      end
    end
    reset = 1'b0; tick = 1'b0; attempt_move = 2'b00;
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
